// File: rtl/encoder_lane_loader.sv
// Serial lane loader for the 1600-bit permutation encoder: assembles LANES lanes into raw_data,
// issues a one-cycle start and holds the block until the encoder reports Ready.
module encoder_lane_loader #(
    parameter int unsigned LANE_W = 64,
    parameter int unsigned LANES  = 25,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [LANE_W-1:0]         in_data,
    output logic                      in_ready,
    input  logic                      enc_ready,
    output logic                      enc_start,
    output logic [LANE_W*LANES-1:0]   raw_data,
    output logic [4:0]                lane_cnt,
    output logic                      busy,
    output logic                      blk_done,
    output logic [CNT_W-1:0]          blk_count
);

    localparam logic [4:0] LAST_LANE = 5'(LANES - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   lane_wr;
    logic   blk_fin;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded handshake/control
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        enc_start = 1'b0;
        busy      = 1'b0;
        lane_wr   = 1'b0;
        blk_fin   = 1'b0;
        case (state)
            FILL: begin
                // Gated by reset so upstream sees no ready while reset is held
                in_ready = reset;
                lane_wr  = in_valid && in_ready;
                if (lane_wr && (lane_cnt == LAST_LANE)) begin
                    state_nxt = START;
                end
            end
            START: begin
                // enc_ready deliberately ignored: it may still be high from the previous block
                enc_start = 1'b1;
                busy      = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (enc_ready) begin
                    blk_fin   = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // Lane counter, completion pulse and block counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_cnt  <= 5'd0;
            blk_count <= '0;
            blk_done  <= 1'b0;
        end else begin
            blk_done <= blk_fin;
            if (blk_fin) begin
                lane_cnt  <= 5'd0;
                blk_count <= blk_count + CNT_W'(1);
            end else if (lane_wr) begin
                lane_cnt <= lane_cnt + 5'd1;
            end
        end
    end

    // Block buffer; not cleared between blocks since every lane is rewritten before each start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            raw_data <= '0;
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (lane_wr && (lane_cnt == 5'(i))) begin
                    raw_data[i*LANE_W +: LANE_W] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_encoder_lane_loader.sv
// Directed bench for encoder_lane_loader: vector table for the basic block flow plus
// hand-written sequences for gapped input, held BUSY, mid-block reset and back-to-back blocks.
module tb_encoder_lane_loader;

    localparam int unsigned LANE_W = 64;
    localparam int unsigned LANES  = 25;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned RAW_W  = LANE_W * LANES;
    localparam int unsigned NVEC   = 28;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [LANE_W-1:0] in_data = '0;
    logic              enc_ready = 1'b0;
    logic              in_ready;
    logic              enc_start;
    logic [RAW_W-1:0]  raw_data;
    logic [4:0]        lane_cnt;
    logic              busy;
    logic              blk_done;
    logic [CNT_W-1:0]  blk_count;

    int errors = 0;
    int checks = 0;
    int n_start = 0;
    int n_done = 0;
    logic [RAW_W-1:0] start_raw[$];

    typedef struct {
        logic              v;
        logic [LANE_W-1:0] d;
        logic              er;
        logic              x_rdy;
        logic              x_start;
        logic              x_busy;
        logic [4:0]        x_cnt;
        logic              x_done;
    } vec_t;

    vec_t tbl[NVEC];

    encoder_lane_loader #(.LANE_W(LANE_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .enc_ready (enc_ready),
        .enc_start (enc_start),
        .raw_data  (raw_data),
        .lane_cnt  (lane_cnt),
        .busy      (busy),
        .blk_done  (blk_done),
        .blk_count (blk_count)
    );

    always #5 clk = ~clk;

    // Pulse counters and snapshot of the block presented at each start
    always @(negedge clk) begin
        if (reset) begin
            if (enc_start) begin
                n_start++;
                start_raw.push_back(raw_data);
            end
            if (blk_done) n_done++;
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_raw(input string name, input logic [RAW_W-1:0] act, input logic [RAW_W-1:0] exp);
        int bad;
        checks++;
        if (act !== exp) begin
            errors++;
            bad = -1;
            for (int i = LANES - 1; i >= 0; i--) begin
                if (act[i*LANE_W +: LANE_W] !== exp[i*LANE_W +: LANE_W]) bad = i;
            end
            $display("FAIL %s: lane %0d got %h expected %h", name, bad,
                     act[bad*LANE_W +: LANE_W], exp[bad*LANE_W +: LANE_W]);
        end
    endtask

    logic [RAW_W-1:0] exp_raw;
    logic [RAW_W-1:0] exp_blk[3];
    logic [LANE_W-1:0] a5;
    int ns0;
    int nd0;

    initial begin
        a5 = 64'hA5A5_A5A5_A5A5_A5A5;

        // 25 lanes carrying their index with enc_ready stuck high, then START, BUSY exit, idle
        for (int i = 0; i < int'(LANES); i++) begin
            tbl[i].v = 1'b1;  tbl[i].d = 64'(i);  tbl[i].er = 1'b1;
            tbl[i].x_rdy = (i < 24);  tbl[i].x_start = (i == 24);  tbl[i].x_busy = (i == 24);
            tbl[i].x_cnt = 5'(i + 1);  tbl[i].x_done = 1'b0;
        end
        tbl[25].v = 1'b1;  tbl[25].d = 64'hDEAD_BEEF_0000_0001;  tbl[25].er = 1'b1;
        tbl[25].x_rdy = 1'b0;  tbl[25].x_start = 1'b0;  tbl[25].x_busy = 1'b1;
        tbl[25].x_cnt = 5'd25;  tbl[25].x_done = 1'b0;
        tbl[26].v = 1'b0;  tbl[26].d = '0;  tbl[26].er = 1'b1;
        tbl[26].x_rdy = 1'b1;  tbl[26].x_start = 1'b0;  tbl[26].x_busy = 1'b0;
        tbl[26].x_cnt = 5'd0;  tbl[26].x_done = 1'b1;
        tbl[27].v = 1'b0;  tbl[27].d = '0;  tbl[27].er = 1'b1;
        tbl[27].x_rdy = 1'b1;  tbl[27].x_start = 1'b0;  tbl[27].x_busy = 1'b0;
        tbl[27].x_cnt = 5'd0;  tbl[27].x_done = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_enc_start", 64'(enc_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_blk_done", 64'(blk_done), 64'd0);
        chk("rst_lane_cnt", 64'(lane_cnt), 64'd0);
        chk("rst_blk_count", 64'(blk_count), 64'd0);
        chk_raw("rst_raw", raw_data, '0);
        reset = 1'b1;
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        for (int n = 0; n < int'(NVEC); n++) begin
            in_valid  = tbl[n].v;
            in_data   = tbl[n].d;
            enc_ready = tbl[n].er;
            step();
            chk($sformatf("vec%0d_in_ready", n), 64'(in_ready), 64'(tbl[n].x_rdy));
            chk($sformatf("vec%0d_enc_start", n), 64'(enc_start), 64'(tbl[n].x_start));
            chk($sformatf("vec%0d_busy", n), 64'(busy), 64'(tbl[n].x_busy));
            chk($sformatf("vec%0d_lane_cnt", n), 64'(lane_cnt), 64'(tbl[n].x_cnt));
            chk($sformatf("vec%0d_blk_done", n), 64'(blk_done), 64'(tbl[n].x_done));
        end
        for (int i = 0; i < int'(LANES); i++) exp_raw[i*LANE_W +: LANE_W] = 64'(i);
        chk("t1_lane0", raw_data[63:0], 64'd0);
        chk("t1_lane24", raw_data[1599:1536], 64'd24);
        chk_raw("t1_raw", raw_data, exp_raw);
        chk("t2_blk_count", 64'(blk_count), 64'd1);
        chk("t2_n_start", 64'(n_start), 64'd1);
        chk("t2_n_done", 64'(n_done), 64'd1);

        // Gapped input: only valid cycles transfer
        enc_ready = 1'b0;
        for (int k = 0; k < 49; k++) begin
            in_valid = (k % 2 == 0);
            in_data  = in_valid ? a5 : 64'h0123_4567_89AB_CDEF;
            step();
            chk($sformatf("gap%0d_lane_cnt", k), 64'(lane_cnt), 64'(k / 2 + 1));
            chk($sformatf("gap%0d_enc_start", k), 64'(enc_start), 64'(k == 48));
        end
        for (int i = 0; i < int'(LANES); i++) exp_raw[i*LANE_W +: LANE_W] = a5;
        chk_raw("gap_raw", raw_data, exp_raw);

        // Upstream keeps pushing while the encoder is busy
        in_valid = 1'b1;
        in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("hold%0d_in_ready", k), 64'(in_ready), 64'd0);
            chk($sformatf("hold%0d_lane_cnt", k), 64'(lane_cnt), 64'd25);
            chk($sformatf("hold%0d_busy", k), 64'(busy), 64'd1);
        end
        chk_raw("hold_raw", raw_data, exp_raw);
        in_valid  = 1'b0;
        enc_ready = 1'b1;
        step();
        chk("hold_exit_done", 64'(blk_done), 64'd1);
        chk("hold_exit_count", 64'(blk_count), 64'd2);
        chk("hold_exit_lane_cnt", 64'(lane_cnt), 64'd0);
        chk("hold_exit_in_ready", 64'(in_ready), 64'd1);
        enc_ready = 1'b0;
        step();
        chk("hold_done_once", 64'(blk_done), 64'd0);

        // Reset in the middle of a block discards it
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h1000 + 64'(i);
            step();
        end
        in_valid = 1'b0;
        chk("mid_lane_cnt", 64'(lane_cnt), 64'd12);
        reset = 1'b0;
        #1;
        chk("mid_rst_lane_cnt", 64'(lane_cnt), 64'd0);
        chk_raw("mid_rst_raw", raw_data, '0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_blk_count", 64'(blk_count), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        ns0 = n_start;
        for (int i = 0; i < int'(LANES); i++) begin
            in_valid = 1'b1;
            in_data  = 64'h2000 + 64'(i);
            exp_raw[i*LANE_W +: LANE_W] = 64'h2000 + 64'(i);
            step();
        end
        in_valid = 1'b0;
        chk("mid_new_start", 64'(enc_start), 64'd1);
        chk_raw("mid_new_raw", raw_data, exp_raw);
        repeat (3) step();
        chk("mid_new_busy", 64'(busy), 64'd1);
        enc_ready = 1'b1;
        step();
        enc_ready = 1'b0;
        chk("mid_new_done", 64'(blk_done), 64'd1);
        chk("mid_new_count", 64'(blk_count), 64'd1);
        step();
        chk("mid_new_n_start", 64'(n_start - ns0), 64'd1);

        // Three consecutive blocks, encoder finishing 20 cycles after each start
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        ns0 = n_start;
        nd0 = n_done;
        start_raw.delete();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < int'(LANES); i++) begin
                in_valid = 1'b1;
                in_data  = 64'hB000_0000_0000_0000 | (64'(b) << 8) | 64'(i);
                exp_blk[b][i*LANE_W +: LANE_W] = in_data;
                step();
            end
            in_valid = 1'b0;
            repeat (19) step();
            enc_ready = 1'b1;
            step();
            enc_ready = 1'b0;
            chk($sformatf("blk%0d_done", b), 64'(blk_done), 64'd1);
            step();
        end
        chk("multi_blk_count", 64'(blk_count), 64'd3);
        chk("multi_n_start", 64'(n_start - ns0), 64'd3);
        chk("multi_n_done", 64'(n_done - nd0), 64'd3);
        chk("multi_snapshots", 64'(start_raw.size()), 64'd3);
        for (int b = 0; b < 3; b++) begin
            if (b < start_raw.size()) chk_raw($sformatf("blk%0d_raw_at_start", b), start_raw[b], exp_blk[b]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
